alu_rs_ordered: RTL and testbench

Parametrised ALU reservation station for the Tomasulo core. It sits between the decoder and the ALU, holds renamed instructions until both operands are available, and snoops N common-data-bus channels (ALU, LSB, ROB, …) for wakeup, including same-cycle bypass at dispatch. It issues the oldest ready entry through a registered valid/ready port to the ALU. It supersedes the fixed 16-entry station with depth, width and CDB-channel-count parameters, age-ordered select, dual-operand wakeup and flush.

---
 rtl/alu_rs_ordered.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_rs_ordered.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_ordered.sv
// ALU reservation station: holds renamed instructions until both operands are
// available, snoops NCDB result buses for wakeup (including bypass at dispatch),
// and issues the oldest ready entry into a registered valid/ready slot.
module alu_rs_ordered #(
    parameter int DEPTH  = 16,
    parameter int NCDB   = 3,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int IMM_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         clr,
    input  logic                         dec_valid,
    input  logic [OP_W-1:0]              dec_op,
    input  logic [IMM_W-1:0]             dec_imm,
    input  logic [ADDR_W-1:0]            dec_pc,
    input  logic [ROB_W-1:0]             dec_rd_tag,
    input  logic                         dec_rs1_ready,
    input  logic                         dec_rs2_ready,
    input  logic [ROB_W-1:0]             dec_rs1_tag,
    input  logic [ROB_W-1:0]             dec_rs2_tag,
    input  logic [DATA_W-1:0]            dec_rs1_value,
    input  logic [DATA_W-1:0]            dec_rs2_value,
    input  logic [NCDB-1:0]              cdb_valid,
    input  logic [NCDB*ROB_W-1:0]        cdb_tag,
    input  logic [NCDB*DATA_W-1:0]       cdb_value,
    output logic                         alu_valid,
    input  logic                         alu_ready,
    output logic [OP_W-1:0]              alu_op,
    output logic [IMM_W-1:0]             alu_imm,
    output logic [ADDR_W-1:0]            alu_pc,
    output logic [ROB_W-1:0]             alu_rd_tag,
    output logic [DATA_W-1:0]            alu_rs1_value,
    output logic [DATA_W-1:0]            alu_rs2_value,
    output logic                         rs_full,
    output logic [$clog2(DEPTH+1)-1:0]   rs_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
        logic [ROB_W-1:0]  rd_tag;
        logic              rs1_ready;
        logic [ROB_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_value;
        logic              rs2_ready;
        logic [ROB_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_value;
    } entry_t;

    logic [DEPTH-1:0]  busy;
    entry_t            ent   [DEPTH];
    // older[j][i] is set when entry j was dispatched before entry i.
    logic [DEPTH-1:0]  older [DEPTH];

    logic [DEPTH-1:0]  ready_vec;
    logic [DEPTH-1:0]  w1_hit, w2_hit;
    logic [DATA_W-1:0] w1_val [DEPTH];
    logic [DATA_W-1:0] w2_val [DEPTH];
    logic              d1_hit, d2_hit;
    logic [DATA_W-1:0] d1_val, d2_val;
    entry_t            new_ent;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_valid;
    logic              accept, slot_load, issue;

    assign rs_full   = (rs_count == CNT_W'(DEPTH));
    assign accept    = rdy && !clr && dec_valid && !rs_full;
    assign slot_load = rdy && !clr && (!alu_valid || alu_ready);
    assign issue     = slot_load && sel_valid;

    // CDB snoop for stored operands and dispatch bypass; lowest channel wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w1_hit = '0;
        w2_hit = '0;
        d1_hit = 1'b0;
        d2_hit = 1'b0;
        d1_val = '0;
        d2_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w1_val[i] = '0;
            w2_val[i] = '0;
        end
        // Walk channels high to low so the lowest matching index is written last.
        for (int k = NCDB-1; k >= 0; k--) begin
            if (cdb_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_tag[k*ROB_W +: ROB_W] == ent[i].rs1_tag) begin
                        w1_hit[i] = 1'b1;
                        w1_val[i] = cdb_value[k*DATA_W +: DATA_W];
                    end
                    if (cdb_tag[k*ROB_W +: ROB_W] == ent[i].rs2_tag) begin
                        w2_hit[i] = 1'b1;
                        w2_val[i] = cdb_value[k*DATA_W +: DATA_W];
                    end
                end
                if (cdb_tag[k*ROB_W +: ROB_W] == dec_rs1_tag) begin
                    d1_hit = 1'b1;
                    d1_val = cdb_value[k*DATA_W +: DATA_W];
                end
                if (cdb_tag[k*ROB_W +: ROB_W] == dec_rs2_tag) begin
                    d2_hit = 1'b1;
                    d2_val = cdb_value[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Entry image written at dispatch, with same-cycle bypass folded in.
    always_comb begin
        new_ent           = '0;
        new_ent.op        = dec_op;
        new_ent.imm       = dec_imm;
        new_ent.pc        = dec_pc;
        new_ent.rd_tag    = dec_rd_tag;
        new_ent.rs1_tag   = dec_rs1_tag;
        new_ent.rs2_tag   = dec_rs2_tag;
        new_ent.rs1_ready = dec_rs1_ready || d1_hit;
        new_ent.rs2_ready = dec_rs2_ready || d2_hit;
        new_ent.rs1_value = dec_rs1_ready ? dec_rs1_value : d1_val;
        new_ent.rs2_value = dec_rs2_ready ? dec_rs2_value : d2_val;
    end

    // Lowest-index free entry at the start of the cycle.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end
    end

    // Oldest ready entry: no other ready entry is older than it.
    always_comb begin
        logic cand;
        cand      = 1'b0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = busy[i] && ent[i].rs1_ready && ent[i].rs2_ready;
        end
        for (int i = 0; i < DEPTH; i++) begin
            cand = ready_vec[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready_vec[j] && older[j][i]) cand = 1'b0;
            end
            if (cand) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Occupancy: busy bits and count.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            busy     <= '0;
            rs_count <= '0;
        end else if (clr) begin
            busy     <= '0;
            rs_count <= '0;
        end else begin
            if (issue)  busy[sel_idx]  <= 1'b0;
            if (accept) busy[free_idx] <= 1'b1;
            if (accept && !issue)      rs_count <= rs_count + CNT_W'(1);
            else if (!accept && issue) rs_count <= rs_count - CNT_W'(1);
        end
    end

    // Entry payload, wakeup and age matrix.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; busy gates every use, so stale contents are harmless.
        if (rdy && !clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && !ent[i].rs1_ready && w1_hit[i]) begin
                    ent[i].rs1_ready <= 1'b1;
                    ent[i].rs1_value <= w1_val[i];
                end
                if (busy[i] && !ent[i].rs2_ready && w2_hit[i]) begin
                    ent[i].rs2_ready <= 1'b1;
                    ent[i].rs2_value <= w2_val[i];
                end
            end
        end
        if (accept) begin
            ent[free_idx] <= new_ent;
            // The new entry is younger than everything already present.
            for (int j = 0; j < DEPTH; j++) begin
                older[free_idx][j] <= 1'b0;
                if (j != int'(free_idx)) older[j][free_idx] <= 1'b1;
            end
        end
    end

    // Issue slot toward the ALU; holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_valid     <= 1'b0;
            alu_op        <= '0;
            alu_imm       <= '0;
            alu_pc        <= '0;
            alu_rd_tag    <= '0;
            alu_rs1_value <= '0;
            alu_rs2_value <= '0;
        end else if (clr) begin
            alu_valid <= 1'b0;
        end else if (slot_load) begin
            alu_valid <= sel_valid;
            if (sel_valid) begin
                alu_op        <= ent[sel_idx].op;
                alu_imm       <= ent[sel_idx].imm;
                alu_pc        <= ent[sel_idx].pc;
                alu_rd_tag    <= ent[sel_idx].rd_tag;
                alu_rs1_value <= ent[sel_idx].rs1_value;
                alu_rs2_value <= ent[sel_idx].rs2_value;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_ordered.sv
// Self-checking bench for alu_rs_ordered: directed scenarios plus randomized
// traffic compared against a queue-based model kept in dispatch order.
module tb_alu_rs_ordered;

    localparam int DEPTH  = 16;
    localparam int NCDB   = 3;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   rst, rdy, clr;
    logic                   dec_valid;
    logic [OP_W-1:0]        dec_op;
    logic [IMM_W-1:0]       dec_imm;
    logic [ADDR_W-1:0]      dec_pc;
    logic [ROB_W-1:0]       dec_rd_tag;
    logic                   dec_rs1_ready, dec_rs2_ready;
    logic [ROB_W-1:0]       dec_rs1_tag, dec_rs2_tag;
    logic [DATA_W-1:0]      dec_rs1_value, dec_rs2_value;
    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*ROB_W-1:0]  cdb_tag;
    logic [NCDB*DATA_W-1:0] cdb_value;
    logic                   alu_valid, alu_ready;
    logic [OP_W-1:0]        alu_op;
    logic [IMM_W-1:0]       alu_imm;
    logic [ADDR_W-1:0]      alu_pc;
    logic [ROB_W-1:0]       alu_rd_tag;
    logic [DATA_W-1:0]      alu_rs1_value, alu_rs2_value;
    logic                   rs_full;
    logic [CNT_W-1:0]       rs_count;

    always #5 clk = ~clk;

    alu_rs_ordered #(
        .DEPTH(DEPTH), .NCDB(NCDB), .ROB_W(ROB_W), .DATA_W(DATA_W),
        .OP_W(OP_W), .IMM_W(IMM_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .dec_valid(dec_valid), .dec_op(dec_op), .dec_imm(dec_imm), .dec_pc(dec_pc),
        .dec_rd_tag(dec_rd_tag), .dec_rs1_ready(dec_rs1_ready), .dec_rs2_ready(dec_rs2_ready),
        .dec_rs1_tag(dec_rs1_tag), .dec_rs2_tag(dec_rs2_tag),
        .dec_rs1_value(dec_rs1_value), .dec_rs2_value(dec_rs2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_rd_tag(alu_rd_tag),
        .alu_rs1_value(alu_rs1_value), .alu_rs2_value(alu_rs2_value),
        .rs_full(rs_full), .rs_count(rs_count)
    );

    // Reference model: queue of waiting instructions, oldest at the front.
    typedef struct {
        logic [OP_W-1:0]   op;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
        logic [ROB_W-1:0]  rd;
        logic              r1rdy;
        logic [ROB_W-1:0]  r1tag;
        logic [DATA_W-1:0] r1val;
        logic              r2rdy;
        logic [ROB_W-1:0]  r2tag;
        logic [DATA_W-1:0] r2val;
    } m_ent_t;

    m_ent_t           mq[$];
    m_ent_t           m_slot;
    logic             m_valid;
    logic [ROB_W-1:0] issued_rd[$];
    int               n_tests = 0;
    int               n_fail  = 0;

    // First (lowest) valid channel carrying the tag, if any.
    function automatic bit snoop(input logic [ROB_W-1:0] tag, output logic [DATA_W-1:0] v);
        v = '0;
        for (int k = 0; k < NCDB; k++) begin
            if (cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == tag) begin
                v = cdb_value[k*DATA_W +: DATA_W];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_edge();
        m_ent_t            e;
        m_ent_t            sel_e;
        int                sel;
        bit                acc, load, hit;
        logic [DATA_W-1:0] v;
        if (!rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_slot  = '{default: '0};
            return;
        end
        if (clr) begin
            mq.delete();
            m_valid = 1'b0;
            return;
        end
        if (!rdy) return;
        acc  = dec_valid && (mq.size() < DEPTH);
        load = !m_valid || alu_ready;
        sel  = -1;
        if (load) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (sel < 0 && mq[i].r1rdy && mq[i].r2rdy) sel = i;
            end
        end
        if (sel >= 0) sel_e = mq[sel];
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (!e.r1rdy) begin
                hit = snoop(e.r1tag, v);
                if (hit) begin e.r1rdy = 1'b1; e.r1val = v; end
            end
            if (!e.r2rdy) begin
                hit = snoop(e.r2tag, v);
                if (hit) begin e.r2rdy = 1'b1; e.r2val = v; end
            end
            mq[i] = e;
        end
        if (load) begin
            if (sel >= 0) begin
                m_slot  = sel_e;
                m_valid = 1'b1;
                mq.delete(sel);
            end else begin
                m_valid = 1'b0;
            end
        end
        if (acc) begin
            e.op = dec_op; e.imm = dec_imm; e.pc = dec_pc; e.rd = dec_rd_tag;
            e.r1rdy = dec_rs1_ready; e.r1tag = dec_rs1_tag; e.r1val = dec_rs1_value;
            e.r2rdy = dec_rs2_ready; e.r2tag = dec_rs2_tag; e.r2val = dec_rs2_value;
            if (!e.r1rdy) begin
                hit = snoop(e.r1tag, v);
                if (hit) begin e.r1rdy = 1'b1; e.r1val = v; end
            end
            if (!e.r2rdy) begin
                hit = snoop(e.r2tag, v);
                if (hit) begin e.r2rdy = 1'b1; e.r2val = v; end
            end
            mq.push_back(e);
        end
    endtask

    // One clock: model follows the edge, outputs are observed on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (alu_valid) issued_rd.push_back(alu_rd_tag);
    endtask

    task automatic set_idle();
        dec_valid = 1'b0;
        cdb_valid = '0;
        clr       = 1'b0;
        rdy       = 1'b1;
        alu_ready = 1'b1;
    endtask

    task automatic set_dec(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rd,
                           input logic r1rdy, input logic [ROB_W-1:0] r1tag, input logic [DATA_W-1:0] r1val,
                           input logic r2rdy, input logic [ROB_W-1:0] r2tag, input logic [DATA_W-1:0] r2val);
        dec_valid     = 1'b1;
        dec_op        = op;
        dec_imm       = $urandom;
        dec_pc        = $urandom;
        dec_rd_tag    = rd;
        dec_rs1_ready = r1rdy;
        dec_rs1_tag   = r1tag;
        dec_rs1_value = r1val;
        dec_rs2_ready = r2rdy;
        dec_rs2_tag   = r2tag;
        dec_rs2_value = r2val;
    endtask

    task automatic set_cdb(input int k, input logic [ROB_W-1:0] tag, input logic [DATA_W-1:0] val);
        cdb_valid[k]                 = 1'b1;
        cdb_tag[k*ROB_W +: ROB_W]    = tag;
        cdb_value[k*DATA_W +: DATA_W] = val;
    endtask

    task automatic clean();
        set_idle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    task automatic randomize_inputs();
        rdy           = ($urandom_range(0, 9) != 0);
        clr           = ($urandom_range(0, 49) == 0);
        alu_ready     = ($urandom_range(0, 9) < 7);
        dec_valid     = ($urandom_range(0, 9) < 6);
        dec_op        = OP_W'($urandom);
        dec_imm       = $urandom;
        dec_pc        = $urandom;
        dec_rd_tag    = ROB_W'($urandom);
        dec_rs1_ready = 1'($urandom);
        dec_rs2_ready = 1'($urandom);
        dec_rs1_tag   = ROB_W'($urandom);
        dec_rs2_tag   = ROB_W'($urandom);
        dec_rs1_value = $urandom;
        dec_rs2_value = $urandom;
        for (int k = 0; k < NCDB; k++) begin
            cdb_valid[k]                  = ($urandom_range(0, 9) < 3);
            cdb_tag[k*ROB_W +: ROB_W]     = ROB_W'($urandom);
            cdb_value[k*DATA_W +: DATA_W] = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) begin
            randomize_inputs();
            cycle();
        end
        n_tests++;
        if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", alu_valid); end
        n_tests++;
        if (rs_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rs_count); end
        n_tests++;
        if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", rs_full); end
        n_tests++;
        if ({alu_op, alu_imm, alu_pc, alu_rd_tag, alu_rs1_value, alu_rs2_value} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got op=%0h rs1=%0h rs2=%0h expected all 0", alu_op, alu_rs1_value, alu_rs2_value);
        end
        set_idle();
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_simple_issue();
        set_idle();
        set_dec(6'h01, 4'd2, 1'b1, '0, 32'd5, 1'b1, '0, 32'd7);
        cycle();
        dec_valid = 1'b0;
        cycle();
        n_tests++;
        if (alu_valid !== 1'b1 || alu_op !== 6'h01 || alu_rs1_value !== 32'd5 ||
            alu_rs2_value !== 32'd7 || alu_rd_tag !== 4'd2) begin
            n_fail++;
            $display("FAIL simple_issue: got v=%0b op=%0h rs1=%0h rs2=%0h rd=%0h expected v=1 op=1 rs1=5 rs2=7 rd=2",
                     alu_valid, alu_op, alu_rs1_value, alu_rs2_value, alu_rd_tag);
        end
        cycle();
        n_tests++;
        if (alu_valid !== 1'b0 || rs_count !== '0) begin
            n_fail++;
            $display("FAIL simple_drain: got v=%0b count=%0d expected v=0 count=0", alu_valid, rs_count);
        end
    endtask

    task automatic test_fill_drain();
        set_idle();
        for (int i = 0; i <= DEPTH; i++) begin
            set_dec(OP_W'(i), ROB_W'(i), 1'b0, 4'd5, '0, 1'b0, 4'd5, '0);
            cycle();
        end
        n_tests++;
        if (rs_count !== CNT_W'(DEPTH) || rs_full !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full: got count=%0d full=%0b expected count=%0d full=1", rs_count, rs_full, DEPTH);
        end
        dec_valid = 1'b0;
        set_cdb(1, 4'd5, 32'h1234);
        cycle();
        cdb_valid = '0;
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (alu_valid !== 1'b1 || alu_op !== OP_W'(i) ||
                alu_rs1_value !== 32'h1234 || alu_rs2_value !== 32'h1234) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got v=%0b op=%0d rs1=%0h rs2=%0h expected v=1 op=%0d rs1=1234 rs2=1234",
                         i, alu_valid, alu_op, alu_rs1_value, alu_rs2_value, i);
            end
            cycle();
        end
        n_tests++;
        if (alu_valid !== 1'b0 || rs_count !== '0) begin
            n_fail++;
            $display("FAIL drain_empty: got v=%0b count=%0d expected v=0 count=0", alu_valid, rs_count);
        end
    endtask

    task automatic test_age_order();
        logic [ROB_W-1:0] exp_rd [5];
        exp_rd = '{4'd1, 4'd2, 4'd13, 4'd10, 4'd11};
        set_idle();
        issued_rd.delete();
        set_dec(6'd1, 4'd1, 1'b0, 4'd9, '0, 1'b1, '0, 32'd1);        // X -> idx0
        cycle();
        set_dec(6'd2, 4'd2, 1'b0, 4'd10, '0, 1'b1, '0, 32'd2);       // Y -> idx1
        cycle();
        set_dec(6'd3, 4'd10, 1'b0, 4'd3, '0, 1'b1, '0, 32'd3);       // A -> idx2
        cycle();
        dec_valid = 1'b0;
        set_cdb(0, 4'd9, 32'h99);
        cycle();
        cdb_valid = '0;
        repeat (3) cycle();
        set_dec(6'd4, 4'd11, 1'b1, '0, 32'd4, 1'b0, 4'd4, '0);       // B -> idx0
        cycle();
        dec_valid = 1'b0;
        set_cdb(0, 4'd10, 32'hA0);
        cycle();
        cdb_valid = '0;
        repeat (3) cycle();
        set_dec(6'd5, 4'd13, 1'b1, '0, 32'd5, 1'b1, '0, 32'd6);      // D -> idx1
        cycle();
        dec_valid = 1'b0;
        set_cdb(0, 4'd4, 32'h44);
        set_cdb(2, 4'd3, 32'h33);
        cycle();
        cdb_valid = '0;
        repeat (6) cycle();
        n_tests++;
        if (issued_rd.size() != 5) begin
            n_fail++;
            $display("FAIL age_count: got %0d issues expected 5", issued_rd.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < issued_rd.size()) begin
                n_tests++;
                if (issued_rd[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("FAIL age_order[%0d]: got rd=%0d expected rd=%0d", i, issued_rd[i], exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure_bypass();
        set_idle();
        alu_ready = 1'b0;
        set_dec(6'd7, 4'd7, 1'b0, 4'd7, '0, 1'b1, '0, 32'd5);
        set_cdb(0, 4'd7, 32'hAB);
        cycle();
        dec_valid = 1'b0;
        cdb_valid = '0;
        cycle();
        repeat (3) begin
            n_tests++;
            if (alu_valid !== 1'b1 || alu_rs1_value !== 32'hAB || alu_rs2_value !== 32'd5 || alu_rd_tag !== 4'd7) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%0b rs1=%0h rs2=%0h rd=%0h expected v=1 rs1=ab rs2=5 rd=7",
                         alu_valid, alu_rs1_value, alu_rs2_value, alu_rd_tag);
            end
            cycle();
        end
        alu_ready = 1'b1;
        n_tests++;
        if (alu_valid !== 1'b1 || alu_rs1_value !== 32'hAB) begin
            n_fail++;
            $display("FAIL bp_before_accept: got v=%0b rs1=%0h expected v=1 rs1=ab", alu_valid, alu_rs1_value);
        end
        cycle();
        n_tests++;
        if (alu_valid !== 1'b0 || rs_count !== '0) begin
            n_fail++;
            $display("FAIL bp_accepted: got v=%0b count=%0d expected v=0 count=0", alu_valid, rs_count);
        end
    endtask

    task automatic test_flush();
        set_idle();
        alu_ready = 1'b0;
        set_dec(6'd8, 4'd3, 1'b1, '0, 32'd1, 1'b1, '0, 32'd2);
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_dec(OP_W'(9 + i), ROB_W'(4 + i), 1'b0, 4'd12, '0, 1'b1, '0, '0);
            cycle();
        end
        dec_valid = 1'b0;
        cycle();
        n_tests++;
        if (alu_valid !== 1'b1 || rs_count !== CNT_W'(5)) begin
            n_fail++;
            $display("FAIL flush_setup: got v=%0b count=%0d expected v=1 count=5", alu_valid, rs_count);
        end
        clr = 1'b1;
        set_dec(6'h3F, 4'd15, 1'b1, '0, '0, 1'b1, '0, '0);
        cycle();
        n_tests++;
        if (alu_valid !== 1'b0 || rs_count !== '0 || rs_full !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%0b count=%0d full=%0b expected v=0 count=0 full=0",
                     alu_valid, rs_count, rs_full);
        end
        clr       = 1'b0;
        dec_valid = 1'b0;
        alu_ready = 1'b1;
        set_cdb(0, 4'd12, 32'h5A);
        cycle();
        cdb_valid = '0;
        repeat (5) begin
            n_tests++;
            if (alu_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_issue: got v=%0b rd=%0h expected v=0", alu_valid, alu_rd_tag);
            end
            cycle();
        end
    endtask

    task automatic test_full_boundary();
        set_idle();
        alu_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            set_dec(OP_W'(i), ROB_W'(i), 1'b1, '0, 32'(i), 1'b1, '0, 32'(i));
            cycle();
        end
        n_tests++;
        if (rs_count !== CNT_W'(DEPTH) || rs_full !== 1'b1 || alu_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_setup: got count=%0d full=%0b v=%0b expected count=%0d full=1 v=1",
                     rs_count, rs_full, alu_valid, DEPTH);
        end
        alu_ready = 1'b1;
        set_dec(6'h2A, 4'd9, 1'b1, '0, '0, 1'b1, '0, '0);
        cycle();
        n_tests++;
        if (rs_count !== CNT_W'(DEPTH-1) || rs_full !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_reject: got count=%0d full=%0b expected count=%0d full=0",
                     rs_count, rs_full, DEPTH-1);
        end
        clean();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            randomize_inputs();
            cycle();
            n_tests++;
            if (alu_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand_valid@%0d: got %0b expected %0b", c, alu_valid, m_valid);
            end
            n_tests++;
            if (rs_count !== CNT_W'(mq.size()) || rs_full !== (mq.size() == DEPTH)) begin
                n_fail++;
                $display("FAIL rand_count@%0d: got count=%0d full=%0b expected count=%0d", c, rs_count, rs_full, mq.size());
            end
            if (m_valid) begin
                n_tests++;
                if ({alu_op, alu_imm, alu_pc, alu_rd_tag, alu_rs1_value, alu_rs2_value} !==
                    {m_slot.op, m_slot.imm, m_slot.pc, m_slot.rd, m_slot.r1val, m_slot.r2val}) begin
                    n_fail++;
                    $display("FAIL rand_data@%0d: got op=%0h rd=%0h rs1=%0h rs2=%0h expected op=%0h rd=%0h rs1=%0h rs2=%0h",
                             c, alu_op, alu_rd_tag, alu_rs1_value, alu_rs2_value,
                             m_slot.op, m_slot.rd, m_slot.r1val, m_slot.r2val);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        alu_ready = 1'b0;
        set_dec(6'd3, 4'd3, 1'b1, '0, 32'd3, 1'b1, '0, 32'd4);
        cycle();
        set_dec(6'd4, 4'd4, 1'b0, 4'd1, '0, 1'b1, '0, 32'd4);
        cycle();
        dec_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (alu_valid !== 1'b0 || rs_count !== '0 || rs_full !== 1'b0 ||
            {alu_op, alu_imm, alu_pc, alu_rd_tag, alu_rs1_value, alu_rs2_value} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%0b count=%0d op=%0h rs1=%0h expected all 0",
                     alu_valid, rs_count, alu_op, alu_rs1_value);
        end
        cycle();
        rst = 1'b1;
        alu_ready = 1'b1;
        repeat (3) cycle();
        n_tests++;
        if (alu_valid !== 1'b0 || rs_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got v=%0b count=%0d expected v=0 count=0", alu_valid, rs_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        cdb_tag   = '0;
        cdb_value = '0;
        set_idle();
        set_dec('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        dec_valid = 1'b0;
        m_valid   = 1'b0;
        m_slot    = '{default: '0};
        test_reset();
        test_simple_issue();
        test_fill_drain();
        test_age_order();
        test_backpressure_bypass();
        test_flush();
        test_full_boundary();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
